minmax_stream_arbiter: RTL

Round-robin arbiter and sequencer for a shared 4-bit running min/max tracker. It grants one of NREQ requesters exclusive use of the tracker for a burst of samples. It accumulates the burst minimum, maximum and sample count, and presents the result on a held valid/ready output. It sits in front of the min/max datapath so several sample sources can share one tracker instead of each instantiating its own.

---
 rtl/minmax_stream_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/minmax_stream_arbiter.sv
// Round-robin arbiter that lends one shared min/max/count tracker to NREQ sample
// sources, one burst at a time, and holds each burst result on a valid/ready port.
module minmax_stream_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int CW   = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    input  logic [NREQ-1:0]    last,
    output logic [NREQ-1:0]    grant,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IW-1:0]      res_id,
    output logic [DW-1:0]      res_min,
    output logic [DW-1:0]      res_max,
    output logic [CW-1:0]      res_count
);

    // Handshake: a result transfers on any rising edge where res_valid and
    // res_ready are both high; res_* hold steady while res_valid waits.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  cur_id;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  cur_min;
    logic [DW-1:0]  cur_max;

    logic [DW-1:0]  samples [NREQ];
    logic [DW-1:0]  sample;
    logic [DW-1:0]  nxt_min;
    logic [DW-1:0]  nxt_max;
    logic [CW-1:0]  nxt_cnt;
    logic           beat;
    logic           burst_end;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  idx;
    logic           found;

    // Search upward from ptr+1 so the last requester served ranks lowest.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            samples[i] = data[i*DW +: DW];
        end
    end

    // The first beat of a burst seeds min/max regardless of stale tracker contents.
    always_comb begin
        sample    = samples[cur_id];
        beat      = req[cur_id];
        nxt_cnt   = cnt + 1'b1;
        nxt_min   = (cnt == '0 || sample < cur_min) ? sample : cur_min;
        nxt_max   = (cnt == '0 || sample > cur_max) ? sample : cur_max;
        burst_end = last[cur_id] || (nxt_cnt == {CW{1'b1}});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            cur_id    <= '0;
            cnt       <= '0;
            cur_min   <= '0;
            cur_max   <= '0;
            grant     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_min   <= '0;
            res_max   <= '0;
            res_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        cur_id <= sel;
                        cnt    <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        cur_min <= nxt_min;
                        cur_max <= nxt_max;
                        cnt     <= nxt_cnt;
                        if (burst_end) begin
                            grant     <= '0;
                            res_valid <= 1'b1;
                            res_id    <= cur_id;
                            res_min   <= nxt_min;
                            res_max   <= nxt_max;
                            res_count <= nxt_cnt;
                            state     <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= cur_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
